bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the serial pattern-detector stages. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line. Back-to-back words stream with no gap. The serial output drives the detector's bit input directly. When no data is pending, the block drives a constant idle level.

## Interface
- WIDTH, 8: word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: level driven on sout while no word is shifting.

- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- din  input  WIDTH  parallel word; sampled on an accept.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word; equals ~hold_valid & ~rst.
- sout  output  1  serial bit, registered.
- sout_valid  output  1  sout carries a data bit (not idle), registered.
- sof  output  1  high with the first bit of each word, registered.

## Operation
- Accept = din_valid & din_ready at a rising edge.
- Storage:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt, width $clog2(WIDTH)
  - one-entry holding register hold with flag hold_valid
- State machine, states IDLE and SHIFT.
- IDLE:
  - sout = IDLE_BIT, sout_valid = 0.
  - On accept: load sr from din, cnt = 0, go to SHIFT. hold stays empty.
- SHIFT:
  - Each cycle presents the current bit: sr MSB if MSB_FIRST=1, else sr LSB.
  - Shift by one each cycle and increment cnt.
- Last bit (cnt = WIDTH-1), in priority order:
  - hold_valid: load sr from hold, clear hold_valid, cnt = 0, stay in SHIFT.
  - Else, accept this edge: load sr from din, stay in SHIFT.
  - Else: go to IDLE.
- Accept while in SHIFT and not the last-bit edge: word goes to hold, hold_valid = 1.
- Accept in the same edge that drains hold is impossible, because din_ready = 0 while hold_valid = 1.
- sof is 1 exactly on the cycle the first bit of a word is on sout.
- din is ignored unless an accept occurs. din_valid with din_ready = 0 has no effect; the producer must hold din.

## Timing
- Latency: a word accepted from IDLE at edge k drives its first bit on sout in cycle k+1 (after edge k). Its last bit is driven in cycle k+WIDTH.
- Throughput: 1 bit/clk sustained. Next word's first bit immediately follows the previous last bit when hold_valid was set or an accept coincides with the last-bit edge.
- din_ready:
  - low from the cycle after a word enters hold until the edge hold drains into sr;
  - high again one cycle after that drain.
- Reset:
  - While rst = 1, and on the edge it is sampled: state = IDLE, hold_valid = 0, cnt = 0, sr = 0.
  - Outputs: sout = IDLE_BIT, sout_valid = 0, sof = 0, din_ready = 0.
  - din_ready = 1 in the first cycle after rst deasserts.
- Reset mid-word: the partial word and any held word are discarded without flush. No stale bits appear after reset.

## Structure
- Shared package ser_pkg:
  - state enum {SER_IDLE, SER_SHIFT}
  - localparam function for counter width: $clog2(WIDTH), minimum 1
- No sub-module; a single flat module.
- Output registers sit in the same always block as the FSM.

## Test plan
- Single word: WIDTH=8, MSB_FIRST=1, din=8'hD0 accepted at edge 0.
  - sout = 1,1,0,1,0,0,0,0 in cycles 1–8.
  - sof = 1 only in cycle 1; sout_valid = 1 in cycles 1–8; sout = IDLE_BIT from cycle 9.
- Back-to-back: 8'hD0 accepted, then 8'h0D accepted at edge 1 into hold.
  - din_ready = 0 in cycles 2–8, back to 1 in cycle 9.
  - 16 contiguous valid bits 11010000 00001101; sof in cycles 1 and 9.
- LSB-first: MSB_FIRST=0, din=8'h0B → sout = 1,1,0,1,0,0,0,0.
- Backpressure: drive din_valid continuously with incrementing words.
  - No word is lost or duplicated; words appear on sout in order with no idle gap.
- Reset mid-word: assert rst in cycle 4 of a word while hold is full.
  - The next cycle shows sout_valid = 0 and sout = IDLE_BIT; the held word is never emitted.
  - din_ready = 1 the cycle after rst deasserts.
- Idle level: IDLE_BIT=1 with no traffic → sout = 1, sout_valid = 0 for 20 cycles.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
package ser_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words in over valid/ready, one bit
// per clock out on sout, with a one-word holding slot for gapless streaming.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output ser_state_e       state_dbg
);

    // Handshake: a word transfers on a rising edge where din_valid and
    // din_ready are both high; the producer holds din stable otherwise.

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             sof_q, sof_d;
    logic             accept;
    logic             load;

    assign din_ready = ~hold_valid_q & ~rst;
    assign accept    = din_valid & din_ready;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;

        case (state_q)
            SER_IDLE: begin
                if (accept) begin
                    sr_d    = din;
                    cnt_d   = '0;
                    state_d = SER_SHIFT;
                    load    = 1'b1;
                end
            end
            SER_SHIFT: begin
                if (cnt_q == LAST) begin
                    // Held word has priority; ready is low then, so no accept can race it.
                    if (hold_valid_q) begin
                        sr_d         = hold_q;
                        hold_valid_d = 1'b0;
                        cnt_d        = '0;
                        load         = 1'b1;
                    end else if (accept) begin
                        sr_d  = din;
                        cnt_d = '0;
                        load  = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = SER_IDLE;
                    end
                end else begin
                    sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d       = din;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase

        // Outputs are registered from the next shift-register contents.
        sout_valid_d = (state_d == SER_SHIFT);
        sout_d       = sout_valid_d ? (MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0]) : IDLE_BIT;
        sof_d        = load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SER_IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sof_q        <= sof_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sof        = sof_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first, LSB-first and IDLE_BIT=1 instances.
module tb_bit_serializer;
  import ser_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] din_a, din_b, din_c;
  logic         va, vb, vc;
  logic         rdy_a, sout_a, sv_a, sof_a;
  logic         rdy_b, sout_b, sv_b, sof_b;
  logic         rdy_c, sout_c, sv_c, sof_c;
  ser_state_e   st_a, st_b, st_c;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(va), .din_ready(rdy_a),
    .sout(sout_a), .sout_valid(sv_a), .sof(sof_a), .state_dbg(st_a));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(vb), .din_ready(rdy_b),
    .sout(sout_b), .sout_valid(sv_b), .sof(sof_b), .state_dbg(st_b));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_c (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(vc), .din_ready(rdy_c),
    .sout(sout_c), .sout_valid(sv_c), .sof(sof_c), .state_dbg(st_c));

  // cycle log: cyc counts rising edges; each entry is {ready, sof, valid, sout}
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] log_a [0:4095];
  logic [3:0] log_b [0:4095];
  logic [3:0] log_c [0:4095];
  always @(negedge clk) begin
    if (cyc < 4096) begin
      log_a[cyc] = {rdy_a, sof_a, sv_a, sout_a};
      log_b[cyc] = {rdy_b, sof_b, sv_b, sout_b};
      log_c[cyc] = {rdy_c, sof_c, sv_c, sout_c};
    end
  end

  // scoreboard
  int n_total = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] get(input int sel, input int i);
    case (sel)
      0: return log_a[i];
      1: return log_b[i];
      default: return log_c[i];
    endcase
  endfunction

  // driver helper: advance n rising edges, land 1 time unit after the last
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expected serial stream, first bit = bits[nbits-1]; sof every W bits; idle after
  task automatic check_stream(input string name, input int sel, input int base,
                              input logic [15:0] bits, input int nbits);
    logic [3:0] e;
    for (int n = 0; n < nbits; n++) begin
      e = get(sel, base + n);
      chk($sformatf("%s_sout_c%0d", name, n + 1), e[0], bits[nbits-1-n]);
      chk($sformatf("%s_valid_c%0d", name, n + 1), e[1], 1);
      chk($sformatf("%s_sof_c%0d", name, n + 1), e[2], (n % W) == 0);
    end
    e = get(sel, base + nbits);
    chk($sformatf("%s_end_valid", name), e[1], 0);
    chk($sformatf("%s_end_sout", name), e[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int c_start;
    int first;
    int nacc;
    int gaps;
    int sof_err;
    int stray;
    logic acc;
    logic [W-1:0] wv;
    logic [W-1:0] word;
    logic [3:0] e;

    din_a = '0; din_b = '0; din_c = '0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;

    // reset state
    tick(3);
    @(negedge clk);
    chk("rst_sout_a", sout_a, 0);
    chk("rst_valid_a", sv_a, 0);
    chk("rst_sof_a", sof_a, 0);
    chk("rst_ready_a", rdy_a, 0);
    chk("rst_state_a", st_a, SER_IDLE);
    chk("rst_sout_c", sout_c, 1);
    chk("rst_valid_c", sv_c, 0);
    tick(1);
    rst = 1'b0;
    c_start = cyc;
    @(negedge clk);
    chk("rst_release_ready_a", rdy_a, 1);

    // single word, MSB first
    tick(1);
    din_a = 8'hD0; va = 1'b1;
    tick(1);
    base = cyc; va = 1'b0;
    tick(10);
    check_stream("single", 0, base, 16'h00D0, 8);

    // back-to-back via the hold slot
    tick(1);
    din_a = 8'hD0; va = 1'b1;
    tick(1);
    base = cyc; din_a = 8'h0D;
    tick(1);
    va = 1'b0;
    tick(18);
    check_stream("b2b", 0, base, 16'hD00D, 16);
    chk("b2b_ready_c1", log_a[base][3], 1);
    for (int n = 2; n <= 8; n++) chk($sformatf("b2b_ready_c%0d", n), log_a[base+n-1][3], 0);
    chk("b2b_ready_c9", log_a[base+8][3], 1);

    // accept coinciding with the last-bit edge, hold empty
    tick(1);
    din_a = 8'hD0; va = 1'b1;
    tick(1);
    base = cyc; va = 1'b0;
    tick(7);
    din_a = 8'hA5; va = 1'b1;
    tick(1);
    va = 1'b0;
    tick(12);
    check_stream("lastbit", 0, base, 16'hD0A5, 16);
    chk("lastbit_ready_c8", log_a[base+7][3], 1);

    // continuous producer with incrementing words
    exp_q.delete();
    wv = 8'h40; nacc = 0; first = -1;
    tick(1);
    din_a = wv; va = 1'b1;
    for (int k = 0; k < 200 && nacc < 6; k++) begin
      @(negedge clk);
      acc = rdy_a;
      @(posedge clk);
      #1;
      if (acc) begin
        if (first < 0) first = cyc;
        exp_q.push_back(din_a);
        nacc++;
        wv = wv + 8'd1;
        din_a = wv;
      end
    end
    va = 1'b0;
    chk("bp_accepts", nacc, 6);
    tick(60);
    gaps = 0; sof_err = 0;
    if (first < 0) first = 0;
    for (int wi = 0; wi < 6; wi++) begin
      word = '0;
      for (int b = 0; b < W; b++) begin
        e = log_a[first + wi*W + b];
        if (e[1] !== 1'b1) gaps++;
        if (e[2] !== (b == 0)) sof_err++;
        word = {word[W-2:0], e[0]};
      end
      if (exp_q.size() > 0) chk($sformatf("bp_word%0d", wi), word, exp_q.pop_front());
      else chk($sformatf("bp_word%0d_missing", wi), 0, 1);
    end
    chk("bp_gaps", gaps, 0);
    chk("bp_sof", sof_err, 0);
    chk("bp_tail_valid", log_a[first + 6*W][1], 0);

    // reset mid-word with the hold slot full
    tick(1);
    din_a = 8'hD0; va = 1'b1;
    tick(1);
    base = cyc; din_a = 8'h0D;
    tick(1);
    va = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(22);
    chk("mid_ready_c3", log_a[base+2][3], 0);
    chk("mid_valid_c4", log_a[base+3][1], 1);
    chk("mid_valid_c5", log_a[base+4][1], 0);
    chk("mid_sout_c5", log_a[base+4][0], 0);
    chk("mid_sof_c5", log_a[base+4][2], 0);
    chk("mid_ready_c6", log_a[base+5][3], 1);
    stray = 0;
    for (int n = 5; n <= 25; n++) if (log_a[base+n-1][1] !== 1'b0) stray++;
    chk("mid_no_stale_bits", stray, 0);

    // LSB-first
    tick(1);
    din_b = 8'h0B; vb = 1'b1;
    tick(1);
    base = cyc; vb = 1'b0;
    tick(10);
    check_stream("lsb", 1, base, 16'h00D0, 8);

    // idle level with IDLE_BIT=1 and no traffic
    for (int n = 0; n < 20; n++) begin
      e = log_c[c_start + n];
      chk($sformatf("idle1_sout_c%0d", n), e[0], 1);
      chk($sformatf("idle1_valid_c%0d", n), e[1], 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
